riskow_gpio_port: RTL and testbench
===================================

# riskow_gpio_port

Parametrised GPIO peripheral for the Riskow SoC. It is the next generation of the fixed portA/portB blocks in `top`, with these additions:
- configurable pin count;
- synchronised inputs;
- atomic set/clear/toggle writes;
- per-pin rising/falling edge interrupts with a sticky, write-1-to-clear status register.

It sits on the CPU data bus beside RAM and the other IO ports. Its `pinDir`/`pinOut` pins drive the top-level tristate pads.

## Interface
Parameters:
- `WIDTH`, 32: number of pins, 1..32.
- `SYNC_STAGES`, 2: input synchroniser depth, 2..3.
- `OUT_RESET`, 0: reset value of the OUT register (WIDTH bits).

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1: system clock; all state on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `busValid` input 1: access request.
- `busWriteEnable` input 1: 1 = write, 0 = read; sampled with `busValid`.
- `busAddress` input 4: word offset of the register.
- `busDataIn` input 32: write data.
- `busDataOut` output 32: read data, valid while `busReady` is high.
- `busReady` output 1: one-cycle access acknowledge.
- `pinIn` input WIDTH: asynchronous pad inputs.
- `pinOut` output WIDTH: pad output values (the OUT register).
- `pinDir` output WIDTH: per-pin direction; 1 = output driven, 0 = input/high-Z.
- `irq` output 1: level interrupt request to the CPU.

## Operation
Register map (word offsets):
- 0 DIR: read/write.
- 1 OUT: read/write.
- 2 IN: read-only, synchronised pins.
- 3 SET: write `OUT |= d`; reads 0.
- 4 CLR: write `OUT &= ~d`; reads 0.
- 5 TGL: write `OUT ^= d`; reads 0.
- 6 RISE_EN: read/write.
- 7 FALL_EN: read/write.
- 8 STATUS: read; write 1 to clear.
- 9–15: unmapped.

Access rules:
- Bits [31:WIDTH] read 0 and ignore writes.
- Unmapped offsets read 0, ignore writes, and are still acknowledged.

Bus FSM has two states:
- IDLE → ACK when `busValid && !busReady`. The access is performed on that edge: the write is applied, or read data is registered.
- ACK → IDLE unconditionally, so `busReady` is high for exactly one cycle.
- If `busValid` is still high in the cycle after `busReady`, that is a new access.

Input path:
- `pinIn` passes through SYNC_STAGES flops, giving `inSync`.
- One further register holds `inPrev`.
- `rise = inSync & ~inPrev`; `fall = ~inSync & inPrev`.

Interrupts:
- STATUS[i] is set when `(rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i])`.
- STATUS[i] is cleared by writing 1 to STATUS bit i.
- Edges are detected regardless of DIR, so output pins loop back through the pad.
- `irq = |STATUS`, combinational from STATUS flops.

Reset values:
- DIR, RISE_EN, FALL_EN, STATUS: 0.
- OUT: OUT_RESET.
- Sync chain and `inPrev`: 0.
- `busReady`, `busDataOut`, `irq`: 0.

## Timing
- Read/write latency: one cycle from `busValid` sampled to `busReady`.
- Write effects (OUT, DIR, enables, STATUS clear) are visible on `pinOut`/`pinDir`/`irq` in the same cycle `busReady` rises.
- A pin change becomes visible in IN after SYNC_STAGES clock edges.
- STATUS sets, and `irq` rises, one edge after that: SYNC_STAGES+1 edges from the pin change.
- A pin pulse shorter than one clock may be missed; no requirement applies.
- Simultaneous W1C and new edge on the same bit: set wins, so the bit stays 1.
- Enabling RISE_EN/FALL_EN never retroactively reports past edges.
- Changing DIR does not alter OUT.
- Reset asserted mid-access: all state clears immediately, `busReady` drops, and the access is lost.
- Deasserting reset produces no spurious edge, because the chain and `inPrev` both start at 0.

## Structure
- Package `riskow_gpio_pkg` holds the register offset constants (REG_DIR … REG_STATUS) and the bus FSM state enum.
- One sub-module, `riskow_sync_edge #(WIDTH, SYNC_STAGES)`: synchroniser chain plus `inPrev`, outputs `inSync`, `rise`, `fall`.
- Top-level module holds the register file, the bus FSM and the interrupt logic.
- Target size 150–250 lines.

## Test plan
- Reset: hold `reset` = 0 with OUT_RESET = 'h5. Required: `pinOut` = 'h5; `pinDir`, `irq`, `busReady` = 0; reading DIR returns 0.
- Atomic ops, WIDTH = 8:
  - write OUT = 'hF0, then SET 'h0F → OUT reads 'hFF;
  - CLR 'h81 → 'h7E;
  - TGL 'hFF → 'h81.
  - Each write is acked in exactly one cycle.
- Width masking, WIDTH = 8: write DIR = 'hFFFF_FFFF → reads 'h0000_00FF. Read offset 12 → 0 and acked.
- Input sync, SYNC_STAGES = 2: drive `pinIn[3]` 0→1. IN[3] reads 1 only after two edges; STATUS stays 0 with enables off.
- Edge interrupt:
  - set RISE_EN = 'h8 and toggle `pinIn[3]` 0→1 → STATUS = 'h8 and `irq` = 1 three edges after the change;
  - falling edge with FALL_EN = 0 → no change;
  - write STATUS = 'h8 → `irq` = 0.
- W1C collision: time the W1C of bit 3 onto the same edge as a new rising edge on pin 3 → STATUS[3] stays 1. Then assert reset mid-read → `busReady` = 0 and all registers are at their reset values.

Source files
------------

// File: rtl/riskow_gpio_pkg.sv
// Shared definitions for the Riskow GPIO port: register word offsets and bus FSM states.
package riskow_gpio_pkg;

    localparam logic [3:0] REG_DIR     = 4'd0;
    localparam logic [3:0] REG_OUT     = 4'd1;
    localparam logic [3:0] REG_IN      = 4'd2;
    localparam logic [3:0] REG_SET     = 4'd3;
    localparam logic [3:0] REG_CLR     = 4'd4;
    localparam logic [3:0] REG_TGL     = 4'd5;
    localparam logic [3:0] REG_RISE_EN = 4'd6;
    localparam logic [3:0] REG_FALL_EN = 4'd7;
    localparam logic [3:0] REG_STATUS  = 4'd8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } bus_state_e;

endpackage

// File: rtl/riskow_sync_edge.sv
// Pad input synchroniser plus one history register for rising/falling edge detection.
module riskow_sync_edge #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pinIn,
    output logic [WIDTH-1:0] inSync,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;

    // Chain and history both clear to 0, so leaving reset never looks like an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= pinIn;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign inSync = sync_q[SYNC_STAGES-1];
    assign rise   = inSync & ~prev_q;
    assign fall   = ~inSync & prev_q;

endmodule

// File: rtl/riskow_gpio_port.sv
// Riskow GPIO port: register file, one-cycle-ack bus FSM and sticky edge interrupts.
module riskow_gpio_port
    import riskow_gpio_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] OUT_RESET   = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             busValid,
    input  logic             busWriteEnable,
    input  logic [3:0]       busAddress,
    input  logic [31:0]      busDataIn,
    output logic [31:0]      busDataOut,
    output logic             busReady,
    input  logic [WIDTH-1:0] pinIn,
    output logic [WIDTH-1:0] pinOut,
    output logic [WIDTH-1:0] pinDir,
    output logic             irq
);

    // Bus handshake: an access is taken on the edge where busValid is high and busReady
    // is low; busReady then stays high for exactly one cycle with read data alongside.

    bus_state_e       state_q, state_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] status_q, status_d;
    logic [31:0]      rdata_q, rdata_d;

    logic [WIDTH-1:0] in_sync, rise, fall;
    logic [WIDTH-1:0] wdata, w1c, rsel;
    logic             access, wr, rd;

    riskow_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk    (clk),
        .reset  (reset),
        .pinIn  (pinIn),
        .inSync (in_sync),
        .rise   (rise),
        .fall   (fall)
    );

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        out_d     = out_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        w1c       = '0;
        rsel      = '0;
        rdata_d   = '0;

        access = (state_q == ST_IDLE) && busValid;
        wr     = access && busWriteEnable;
        rd     = access && !busWriteEnable;
        wdata  = busDataIn[WIDTH-1:0];

        case (state_q)
            ST_IDLE: if (busValid) state_d = ST_ACK;
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (wr) begin
            case (busAddress)
                REG_DIR:     dir_d     = wdata;
                REG_OUT:     out_d     = wdata;
                REG_SET:     out_d     = out_q | wdata;
                REG_CLR:     out_d     = out_q & ~wdata;
                REG_TGL:     out_d     = out_q ^ wdata;
                REG_RISE_EN: rise_en_d = wdata;
                REG_FALL_EN: fall_en_d = wdata;
                REG_STATUS:  w1c       = wdata;
                default:     ;
            endcase
        end

        case (busAddress)
            REG_DIR:     rsel = dir_q;
            REG_OUT:     rsel = out_q;
            REG_IN:      rsel = in_sync;
            REG_RISE_EN: rsel = rise_en_q;
            REG_FALL_EN: rsel = fall_en_q;
            REG_STATUS:  rsel = status_q;
            default:     rsel = '0;
        endcase
        // Outside a read acceptance the data register returns to 0 as busReady falls.
        if (rd) rdata_d[WIDTH-1:0] = rsel;

        // A fresh edge on the same cycle as a write-1-to-clear keeps the bit set.
        status_d = (status_q & ~w1c) | (rise & rise_en_q) | (fall & fall_en_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            dir_q     <= '0;
            out_q     <= OUT_RESET;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            out_q     <= out_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
            rdata_q   <= rdata_d;
        end
    end

    assign busReady   = (state_q == ST_ACK);
    assign busDataOut = rdata_q;
    assign pinOut     = out_q;
    assign pinDir     = dir_q;
    assign irq        = |status_q;

endmodule

// File: tb/tb_riskow_gpio_port.sv
// Directed bench for riskow_gpio_port (WIDTH=8, SYNC_STAGES=2, OUT_RESET=5) with a read scoreboard.
module tb_riskow_gpio_port;

    localparam int W = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        busValid;
    logic        busWriteEnable;
    logic [3:0]  busAddress;
    logic [31:0] busDataIn;
    logic [31:0] busDataOut;
    logic        busReady;
    logic [W-1:0] pinIn;
    logic [W-1:0] pinOut;
    logic [W-1:0] pinDir;
    logic        irq;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    riskow_gpio_port #(
        .WIDTH       (W),
        .SYNC_STAGES (2),
        .OUT_RESET   (8'h05)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .busValid       (busValid),
        .busWriteEnable (busWriteEnable),
        .busAddress     (busAddress),
        .busDataIn      (busDataIn),
        .busDataOut     (busDataOut),
        .busReady       (busReady),
        .pinIn          (pinIn),
        .pinOut         (pinOut),
        .pinDir         (pinDir),
        .irq            (irq)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    // driver: one bus access, checks latency, read data from scoreboard, and ack width
    task automatic bus_xfer(input logic we, input logic [3:0] addr, input logic [31:0] data);
        int cyc;
        logic [31:0] exp;
        @(negedge clk);
        busValid = 1'b1;
        busWriteEnable = we;
        busAddress = addr;
        busDataIn = data;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (!busReady && cyc < 4);
        check("ack_latency", 32'(cyc), 32'd1);
        if (!we) begin
            exp = exp_q.pop_front();
            check("rdata", busDataOut, exp);
        end
        @(negedge clk);
        busValid = 1'b0;
        busWriteEnable = 1'b0;
        @(posedge clk);
        #1;
        check("ack_drop", {31'd0, busReady}, 32'd0);
    endtask

    task automatic bus_write(input logic [3:0] addr, input logic [31:0] data);
        bus_xfer(1'b1, addr, data);
    endtask

    task automatic bus_read(input logic [3:0] addr, input logic [31:0] exp);
        exp_q.push_back(exp);
        bus_xfer(1'b0, addr, 32'd0);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
    endtask

    initial begin
        reset = 1'b0;
        busValid = 1'b0;
        busWriteEnable = 1'b0;
        busAddress = 4'd0;
        busDataIn = 32'd0;
        pinIn = '0;

        // reset state
        cycles(2);
        #1;
        check("rst_pinOut", {24'd0, pinOut}, 32'h05);
        check("rst_pinDir", {24'd0, pinDir}, 32'h00);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_busReady", {31'd0, busReady}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        cycles(1);
        bus_read(4'd0, 32'h0);

        // atomic ops
        bus_write(4'd1, 32'hF0);
        check("out_write", {24'd0, pinOut}, 32'hF0);
        bus_write(4'd3, 32'h0F);
        check("set_pin", {24'd0, pinOut}, 32'hFF);
        bus_read(4'd1, 32'hFF);
        bus_write(4'd4, 32'h81);
        bus_read(4'd1, 32'h7E);
        bus_write(4'd5, 32'hFF);
        check("tgl_pin", {24'd0, pinOut}, 32'h81);
        bus_read(4'd1, 32'h81);
        bus_read(4'd3, 32'h0);

        // width masking and unmapped offsets
        bus_write(4'd0, 32'hFFFF_FFFF);
        check("dir_pin", {24'd0, pinDir}, 32'hFF);
        check("dir_keeps_out", {24'd0, pinOut}, 32'h81);
        bus_read(4'd0, 32'h0000_00FF);
        bus_write(4'd12, 32'h1234_5678);
        bus_read(4'd12, 32'h0);
        bus_read(4'd1, 32'h81);

        // input sync: one edge is not enough, two are
        @(negedge clk);
        pinIn[3] = 1'b1;
        @(posedge clk);
        bus_read(4'd2, 32'h00);
        @(negedge clk);
        pinIn[2] = 1'b1;
        cycles(2);
        bus_read(4'd2, 32'h0C);
        bus_read(4'd8, 32'h00);
        check("irq_no_en", {31'd0, irq}, 32'd0);

        // rising edge interrupt, SYNC_STAGES+1 edges after the pin change
        bus_write(4'd6, 32'h08);
        @(negedge clk);
        pinIn[3] = 1'b0;
        cycles(5);
        bus_read(4'd8, 32'h00);
        @(negedge clk);
        pinIn[3] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("irq_early", {31'd0, irq}, 32'd0);
        @(posedge clk); #1;
        check("irq_rise", {31'd0, irq}, 32'd1);
        bus_read(4'd8, 32'h08);

        // falling edge without FALL_EN leaves STATUS alone
        @(negedge clk);
        pinIn[3] = 1'b0;
        cycles(5);
        bus_read(4'd8, 32'h08);
        bus_write(4'd8, 32'h08);
        check("irq_w1c", {31'd0, irq}, 32'd0);
        bus_read(4'd8, 32'h00);

        // W1C lands on the same edge that sets STATUS[3]
        @(negedge clk);
        pinIn[3] = 1'b1;
        cycles(5);
        bus_read(4'd8, 32'h08);
        @(negedge clk);
        pinIn[3] = 1'b0;
        cycles(5);
        @(negedge clk);
        pinIn[3] = 1'b1;
        cycles(2);
        bus_write(4'd8, 32'h08);
        check("collide_irq", {31'd0, irq}, 32'd1);
        bus_read(4'd8, 32'h08);

        // reset during a read: access is lost
        bus_write(4'd7, 32'h10);
        @(negedge clk);
        busValid = 1'b1;
        busWriteEnable = 1'b0;
        busAddress = 4'd0;
        @(posedge clk); #1;
        check("mid_ready_hi", {31'd0, busReady}, 32'd1);
        reset = 1'b0;
        #1;
        check("mid_ready_lo", {31'd0, busReady}, 32'd0);
        check("mid_data", busDataOut, 32'd0);
        check("mid_pinOut", {24'd0, pinOut}, 32'h05);
        check("mid_pinDir", {24'd0, pinDir}, 32'h00);
        check("mid_irq", {31'd0, irq}, 32'd0);
        busValid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        cycles(1);
        bus_read(4'd0, 32'h00);
        bus_read(4'd1, 32'h05);
        bus_read(4'd6, 32'h00);
        bus_read(4'd7, 32'h00);
        cycles(4);
        bus_read(4'd8, 32'h00);
        bus_read(4'd2, 32'h0C);

        check("sb_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
